layer_sequencer: RTL

- Sits between two MLP layers.
- Captures the NN parallel neuron outputs of layer k. Each neuron asserts its valid independently, on any cycle.
- Once all NN values are held, streams them one per transfer, in neuron order, to the serial x_in/x_valid input of layer k+1 over a valid/ready handshake.
- Flags overrun and collect-timeout errors with sticky bits.

---
 rtl/layer_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// Collects the parallel neuron outputs of one MLP layer and replays them, in
// neuron order, as a valid/ready stream into the serial input of the next layer.
module layer_sequencer #(
  parameter int NN        = 10,
  parameter int dataWidth = 16,
  parameter int TIMEOUT   = 1024,
  parameter int IDXW      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           in_valid,
  input  logic [NN*dataWidth-1:0] in_data,
  output logic [dataWidth-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDXW-1:0]         out_idx,
  output logic                    busy,
  output logic                    layer_done,
  output logic                    err_overrun,
  output logic                    err_timeout,
  input  logic                    err_clr
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, STREAM} state_t;

  // Handshake: a transfer happens on a rising edge where out_valid and
  // out_ready are both high; out_data/out_idx hold steady until that edge.
  state_t                 state, state_nxt;
  logic [NN-1:0]          mask, mask_nxt;
  logic [IDXW-1:0]        idx, idx_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [NN-1:0]          cap;
  logic                   done_nxt, ovr_set, tmo_set;
  logic                   xfer, last, full;
  logic [dataWidth-1:0]   data_buf [NN];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mask        <= '0;
      idx         <= '0;
      cnt         <= '0;
      layer_done  <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      mask        <= mask_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      layer_done  <= done_nxt;
      // Setting a flag takes priority over clearing it on the same edge.
      err_overrun <= ovr_set | (err_overrun & ~err_clr);
      err_timeout <= tmo_set | (err_timeout & ~err_clr);
    end
  end

  // Only the first arrival per neuron is kept; duplicates never overwrite.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NN; i++) begin
      if (cap[i]) data_buf[i] <= in_data[i*dataWidth +: dataWidth];
    end
  end

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    cap       = '0;
    done_nxt  = 1'b0;
    ovr_set   = 1'b0;
    tmo_set   = 1'b0;
    xfer      = (state == STREAM) && out_ready;
    last      = (idx == IDXW'(NN - 1));
    full      = &(mask | in_valid);
    case (state)
      IDLE: begin
        cap      = in_valid & ~mask;
        ovr_set  = |(in_valid & mask);
        mask_nxt = mask | in_valid;
        if (|in_valid) begin
          cnt_nxt   = '0;
          state_nxt = full ? STREAM : COLLECT;
        end
      end
      COLLECT: begin
        cap      = in_valid & ~mask;
        ovr_set  = |(in_valid & mask);
        mask_nxt = mask | in_valid;
        cnt_nxt  = cnt + CW'(1);
        if (full) begin
          cnt_nxt   = '0;
          state_nxt = STREAM;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          tmo_set   = 1'b1;
          mask_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      STREAM: begin
        ovr_set = |in_valid;
        if (xfer) begin
          if (last) begin
            idx_nxt   = '0;
            mask_nxt  = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + IDXW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == STREAM);
  assign out_idx   = idx;
  assign busy      = (state != IDLE);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NN; i++) begin
      if (out_valid && idx == IDXW'(i)) out_data = data_buf[i];
    end
  end

endmodule
